fib_seq: RTL and testbench
==========================

# fib_seq

Parametrised generalised-Fibonacci accelerator with the standard ap_ctrl start/done/idle/ready handshake. It computes F(n) for F(0)=a0, F(1)=a1 and F(k)=F(k-1)+F(k-2), using one iteration per clock in a dedicated loop state. It is the drop-in successor to the fixed 32-bit Fibonacci core. It adds a configurable width, user seeds, a wrap/overflow indication and an optional modular mode.

## Interface
- WIDTH, 32, datapath width of n, seeds, modulus and result (≥4)
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst  in  1  synchronous, active-high reset
- ap_start  in  1  request; sampled only in IDLE
- ap_done  out  1  result valid; held until next accepted start
- ap_idle  out  1  combinational, high iff state==IDLE
- ap_ready  out  1  ready for a new start; low while busy
- ap_n  in  WIDTH  index n, unsigned
- ap_a0  in  WIDTH  seed F(0)
- ap_a1  in  WIDTH  seed F(1)
- ap_m  in  WIDTH  modulus; port exists only with FIB_SEQ_MOD_EN
- ap_return  out  WIDTH  F(n), held until overwritten by the next run
- ap_overflow  out  1  sticky per-run flag; meaning depends on configuration

## Operation
- Reset values: state=IDLE, ap_done=0, ap_ready=1, ap_return=0, ap_overflow=0, internal a=0, b=1, cnt=0.
- **IDLE**
  - If ap_start=1: latch cnt←ap_n, a←ap_a0, b←ap_a1 (and m←ap_m), clear ap_done, ap_ready and ap_overflow, go to CHECK.
  - Otherwise hold every output.
- **CHECK**
  - cnt==0: go to DONE, result a.
  - cnt==1: go to DONE, result b.
  - Otherwise: cnt←cnt−1, go to LOOP.
- **LOOP**, one iteration per cycle:
  - a←b, b←step(a,b), cnt←cnt−1.
  - When cnt==1 at the edge, the iteration still executes and the FSM goes to DONE. Total iterations are exactly n−1.
- **DONE**: ap_return←selected result (b after LOOP), ap_done←1, ap_ready←1, go to IDLE.
- step(a,b) without mod: (a+b) mod 2^WIDTH. A carry-out sets ap_overflow (sticky until the next accept).
- ap_start while not IDLE is ignored, with no queueing.
- ap_start held high across DONE→IDLE: the run restarts on the first IDLE cycle, which clears ap_done after one cycle high.
- Input ports are don't-care outside the accept cycle.
- ap_rst at any state aborts the run: outputs go to reset values and no ap_done pulse is produced.
- Unknown state encoding: go to IDLE.

## Timing
- Accept edge = edge 0 (IDLE with ap_start=1).
- ap_done and ap_return update at edge max(n,1)+1. Examples: n=0/1 → edge 2; n=10 → edge 11.
- ap_idle falls in the cycle after edge 0 and rises in the cycle after the DONE edge.
- Back-to-back throughput: one run per max(n,1)+2 cycles.
- No combinational path from inputs to outputs except ap_idle from state.

## Configuration
- Macro: FIB_SEQ_MOD_EN.
- **Defined:**
  - ap_m port exists.
  - step = s≥m ? s−m : s, where s=a+b is computed at WIDTH+1 bits.
  - m=0 means modulus 2^WIDTH (plain wrap).
  - Precondition: a0<m and a1<m. If violated, ap_overflow=1 from the DONE edge and the result is computed by the same rule.
  - ap_overflow is never set by the arithmetic itself.
- **Undefined:** no ap_m port, wrap arithmetic, and carry-driven ap_overflow as described under Operation.

## Structure
- Package fib_seq_pkg:
  - state enum IDLE/CHECK/LOOP/DONE and its width constant;
  - default WIDTH constant.
- One sub-module, fib_seq_addmod: combinational add with carry-out and, under FIB_SEQ_MOD_EN, conditional subtract of m. Parametrised by WIDTH.
- The top holds the FSM, counter, registers and handshake.

## Test plan
- WIDTH=32, a0=0, a1=1, n=10 → ap_return=55, ap_done first high after edge 11, ap_overflow=0.
- n=0 with a0=2, a1=1 → ap_return=2 at edge 2; n=1 → 1 at edge 2; n=5 (Lucas) → 11 at edge 6.
- WIDTH=8, a0=0, a1=1, n=14 → ap_return=121 (377 mod 256), ap_overflow=1; an immediately following n=5 run → 5 with ap_overflow=0.
- FIB_SEQ_MOD_EN, WIDTH=8, m=7, n=10 → ap_return=6. With m=0 → 55. With a0=9, m=7 → ap_overflow=1.
- Start pulsed again at edges 3–5 of an n=10 run → ignored, single result 55 at edge 11. Start held high → a second run is accepted in the first IDLE cycle.
- ap_rst asserted at edge 5 of an n=20 run → next cycle shows ap_idle=1, ap_ready=1, ap_done=0, ap_return=0. A new start with n=3 → 2 at edge 4.

Source files
------------

// File: rtl/fib_seq_pkg.sv
// Shared types and constants for the fib_seq generalised-Fibonacci accelerator.
// FIB_SEQ_MOD_EN (optional) turns the adder into a modular adder and adds the ap_m port.
package fib_seq_pkg;

   localparam int FIB_SEQ_WIDTH = 32;
   localparam int STATE_W       = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      LOOP  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/fib_seq_if.sv
// ap_ctrl handshake plus operand/result bus of fib_seq.
// ap_m only exists when FIB_SEQ_MOD_EN is defined.
interface fib_seq_if
   import fib_seq_pkg::*;
#(
   parameter int WIDTH = FIB_SEQ_WIDTH
);

   // Handshake: ap_start is a request that the slave samples only while ap_idle
   // is high; that edge accepts the operands and drops ap_ready and ap_done. When
   // the result is written, ap_done and ap_ready rise together and ap_done stays
   // high until the next accepted start, so holding ap_start chains runs.
   logic             ap_start;
   logic             ap_done;
   logic             ap_idle;
   logic             ap_ready;
   logic [WIDTH-1:0] ap_n;
   logic [WIDTH-1:0] ap_a0;
   logic [WIDTH-1:0] ap_a1;
`ifdef FIB_SEQ_MOD_EN
   logic [WIDTH-1:0] ap_m;
`endif
   logic [WIDTH-1:0] ap_return;
   logic             ap_overflow;

   modport master (
      output ap_start,
`ifdef FIB_SEQ_MOD_EN
      output ap_m,
`endif
      output ap_n,
      output ap_a0,
      output ap_a1,
      input  ap_done,
      input  ap_idle,
      input  ap_ready,
      input  ap_return,
      input  ap_overflow
   );

   modport slave (
      input  ap_start,
`ifdef FIB_SEQ_MOD_EN
      input  ap_m,
`endif
      input  ap_n,
      input  ap_a0,
      input  ap_a1,
      output ap_done,
      output ap_idle,
      output ap_ready,
      output ap_return,
      output ap_overflow
   );

endinterface

// File: rtl/fib_seq_addmod.sv
// One Fibonacci step: a+b with carry-out, or with FIB_SEQ_MOD_EN a modular add
// that subtracts m once when the WIDTH+1 bit sum reaches it (m=0 gives plain wrap).
module fib_seq_addmod
   import fib_seq_pkg::*;
#(
   parameter int WIDTH = FIB_SEQ_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef FIB_SEQ_MOD_EN
   input  logic [WIDTH-1:0] m,
`else
   output logic             carry,
`endif
   output logic [WIDTH-1:0] sum
);

   logic [WIDTH:0] sum_ext;

   always_comb begin
      sum_ext = {1'b0, a} + {1'b0, b};
`ifdef FIB_SEQ_MOD_EN
      // WIDTH-bit subtraction equals (s - m) mod 2^WIDTH, which also covers
      // out-of-range seeds where s - m may not fit.
      if (sum_ext >= {1'b0, m}) begin
         sum = sum_ext[WIDTH-1:0] - m;
      end else begin
         sum = sum_ext[WIDTH-1:0];
      end
`else
      sum   = sum_ext[WIDTH-1:0];
      carry = sum_ext[WIDTH];
`endif
   end

endmodule

// File: rtl/fib_seq.sv
// Generalised-Fibonacci accelerator: F(0)=a0, F(1)=a1, one iteration per clock.
// FIB_SEQ_MOD_EN selects modular arithmetic with the ap_m port.
module fib_seq
   import fib_seq_pkg::*;
#(
   parameter int WIDTH = FIB_SEQ_WIDTH
) (
   input  logic     ap_clk,
   input  logic     ap_rst,
   fib_seq_if.slave bus,
   output state_t   dbg_state
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] cnt_q;
   logic             use_a_q;
   logic [WIDTH-1:0] step_sum;
`ifdef FIB_SEQ_MOD_EN
   logic [WIDTH-1:0] m_q;
   logic             viol_q;
`else
   logic             step_carry;
`endif

   logic             done_q;
   logic             ready_q;
   logic             ovf_q;
   logic [WIDTH-1:0] ret_q;

   logic             accept;
   logic             check;
   logic             iterate;
   logic             finish;
   logic             idle;

   fib_seq_addmod #(
      .WIDTH (WIDTH)
   ) u_addmod (
      .a     (a_q),
      .b     (b_q),
`ifdef FIB_SEQ_MOD_EN
      .m     (m_q),
`else
      .carry (step_carry),
`endif
      .sum   (step_sum)
   );

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.ap_start) state_d = CHECK;
         CHECK:   state_d = (cnt_q > ONE) ? LOOP : DONE;
         // The iteration seen with cnt==1 is the last of the n-1 steps.
         LOOP:    if (cnt_q == ONE) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      accept  = 1'b0;
      check   = 1'b0;
      iterate = 1'b0;
      finish  = 1'b0;
      idle    = 1'b0;
      case (state_q)
         IDLE: begin
            idle   = 1'b1;
            accept = bus.ap_start;
         end
         CHECK:   check   = 1'b1;
         LOOP:    iterate = 1'b1;
         DONE:    finish  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         a_q     <= '0;
         b_q     <= ONE;
         cnt_q   <= '0;
         use_a_q <= 1'b0;
`ifdef FIB_SEQ_MOD_EN
         m_q     <= '0;
         viol_q  <= 1'b0;
`endif
         done_q  <= 1'b0;
         ready_q <= 1'b1;
         ovf_q   <= 1'b0;
         ret_q   <= '0;
      end else if (accept) begin
         cnt_q   <= bus.ap_n;
         a_q     <= bus.ap_a0;
         b_q     <= bus.ap_a1;
`ifdef FIB_SEQ_MOD_EN
         m_q     <= bus.ap_m;
         viol_q  <= (bus.ap_m != '0) &&
                    ((bus.ap_a0 >= bus.ap_m) || (bus.ap_a1 >= bus.ap_m));
`endif
         done_q  <= 1'b0;
         ready_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (check) begin
         // n==0 is the only case that reports seed a instead of b.
         use_a_q <= (cnt_q == '0);
         if (cnt_q > ONE) cnt_q <= cnt_q - ONE;
      end else if (iterate) begin
         a_q   <= b_q;
         b_q   <= step_sum;
         cnt_q <= cnt_q - ONE;
`ifndef FIB_SEQ_MOD_EN
         if (step_carry) ovf_q <= 1'b1;
`endif
      end else if (finish) begin
         ret_q   <= use_a_q ? a_q : b_q;
         done_q  <= 1'b1;
         ready_q <= 1'b1;
`ifdef FIB_SEQ_MOD_EN
         ovf_q   <= viol_q;
`endif
      end
   end

   assign bus.ap_done     = done_q;
   assign bus.ap_idle     = idle;
   assign bus.ap_ready    = ready_q;
   assign bus.ap_return   = ret_q;
   assign bus.ap_overflow = ovf_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_fib_seq.sv
// Bench for fib_seq: a 32-bit and an 8-bit instance checked against a plain
// arithmetic Fibonacci model; FIB_SEQ_MOD_EN selects the modular scenarios.
module tb_fib_seq;
   import fib_seq_pkg::*;

   logic        ap_clk;
   logic        ap_rst;
   state_t      dbg32;
   state_t      dbg8;
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [32:0] exp_q[$];

   fib_seq_if #(.WIDTH(32)) if32 ();
   fib_seq_if #(.WIDTH(8))  if8 ();

   fib_seq #(.WIDTH(32)) u_dut32 (
      .ap_clk    (ap_clk),
      .ap_rst    (ap_rst),
      .bus       (if32),
      .dbg_state (dbg32)
   );

   fib_seq #(.WIDTH(8)) u_dut8 (
      .ap_clk    (ap_clk),
      .ap_rst    (ap_rst),
      .bus       (if8),
      .dbg_state (dbg8)
   );

   // ---------------- clock / reset ----------------
   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   task automatic apply_reset(input int cycles);
      @(negedge ap_clk);
      ap_rst = 1'b1;
      repeat (cycles) @(negedge ap_clk);
      ap_rst = 1'b0;
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: got no end of test, expected finish before time limit");
      $fatal(1, "time limit");
   end

   // ---------------- reference model ----------------
   // {overflow, F(n)} from the recurrence, using wide integers and explicit wrap.
   function automatic logic [32:0] ref_fib(input int n, input longint unsigned a0,
                                           input longint unsigned a1,
                                           input longint unsigned m, input int w);
      longint unsigned lim;
      longint unsigned f0;
      longint unsigned f1;
      longint unsigned s;
      logic            ovf;
      lim = 64'd1 << w;
      f0  = a0;
      f1  = a1;
      ovf = 1'b0;
`ifdef FIB_SEQ_MOD_EN
      if (m != 0 && (a0 >= m || a1 >= m)) ovf = 1'b1;
`endif
      if (n == 0) return {ovf, 32'(f0)};
      for (int k = 2; k <= n; k++) begin
         s = f0 + f1;
`ifdef FIB_SEQ_MOD_EN
         if (m != 0 && s >= m) s = s - m;
         s = s % lim;
`else
         if (s >= lim) begin
            ovf = 1'b1;
            s   = s - lim;
         end
`endif
         f0 = f1;
         f1 = s;
      end
      return {ovf, 32'(f1)};
   endfunction

   // ---------------- drivers ----------------
   // Returns at the falling edge after the accept edge (edge 0).
   task automatic drive_start(input bit narrow, input int n, input logic [31:0] a0,
                              input logic [31:0] a1, input logic [31:0] m);
      @(negedge ap_clk);
      if (narrow) begin
         if8.ap_n   = 8'(n);
         if8.ap_a0  = a0[7:0];
         if8.ap_a1  = a1[7:0];
`ifdef FIB_SEQ_MOD_EN
         if8.ap_m   = m[7:0];
`endif
         if8.ap_start = 1'b1;
      end else begin
         if32.ap_n  = 32'(n);
         if32.ap_a0 = a0;
         if32.ap_a1 = a1;
`ifdef FIB_SEQ_MOD_EN
         if32.ap_m  = m;
`endif
         if32.ap_start = 1'b1;
      end
      @(posedge ap_clk);
      @(negedge ap_clk);
      if8.ap_start  = 1'b0;
      if32.ap_start = 1'b0;
   endtask

   // lat is the edge index (accept = 0) at which ap_done is first seen, -1 on timeout.
   task automatic wait_done(input bit narrow, output int lat, output logic [31:0] res,
                            output logic ovf);
      lat = -1;
      for (int k = 1; k <= 300; k++) begin
         @(posedge ap_clk);
         @(negedge ap_clk);
         if ((narrow ? if8.ap_done : if32.ap_done) === 1'b1) begin
            lat = k;
            break;
         end
      end
      res = narrow ? {24'd0, if8.ap_return} : if32.ap_return;
      ovf = narrow ? if8.ap_overflow : if32.ap_overflow;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      n_checks++;
      if (if32.ap_idle !== 1'b1) $display("FAIL reset_idle: got %b expected 1", if32.ap_idle);
      else n_pass++;
      n_checks++;
      if (if32.ap_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", if32.ap_ready);
      else n_pass++;
      n_checks++;
      if (if32.ap_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", if32.ap_done);
      else n_pass++;
      n_checks++;
      if (if32.ap_return !== 32'd0) $display("FAIL reset_return: got %0d expected 0", if32.ap_return);
      else n_pass++;
      n_checks++;
      if (if32.ap_overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", if32.ap_overflow);
      else n_pass++;
      n_checks++;
      if (dbg32 !== IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg32, IDLE);
      else n_pass++;
      n_checks++;
      if (if8.ap_done !== 1'b0 || if8.ap_idle !== 1'b1)
         $display("FAIL reset_w8: got done/idle %b%b expected 01", if8.ap_done, if8.ap_idle);
      else n_pass++;
   endtask

   task automatic test_basic();
      int          tn   [4] = '{10, 0, 1, 5};
      int          ta0  [4] = '{0, 2, 2, 2};
      int          texp [4] = '{55, 2, 1, 11};
      int          lat;
      logic [31:0] res;
      logic        ovf;
      logic [32:0] exp;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({1'b0, 32'(texp[i])});
         drive_start(1'b0, tn[i], 32'(ta0[i]), 32'd1, 32'd0);
         n_checks++;
         if (if32.ap_idle !== 1'b0 || if32.ap_ready !== 1'b0 || if32.ap_done !== 1'b0)
            $display("FAIL basic_busy[%0d]: got idle/ready/done %b%b%b expected 000", i,
                     if32.ap_idle, if32.ap_ready, if32.ap_done);
         else n_pass++;
         wait_done(1'b0, lat, res, ovf);
         exp = exp_q.pop_front();
         n_checks++;
         if (res !== exp[31:0]) $display("FAIL basic_return[%0d]: got %0d expected %0d", i, res, exp[31:0]);
         else n_pass++;
         n_checks++;
         if (ovf !== exp[32]) $display("FAIL basic_overflow[%0d]: got %b expected %b", i, ovf, exp[32]);
         else n_pass++;
         n_checks++;
         if (lat !== ((tn[i] < 1) ? 1 : tn[i]) + 1)
            $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, lat, ((tn[i] < 1) ? 1 : tn[i]) + 1);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int          n;
      logic [31:0] a0;
      logic [31:0] a1;
      logic [31:0] m;
      int          lat;
      logic [31:0] res;
      logic        ovf;
      logic [32:0] exp;
      for (int i = 0; i < 24; i++) begin
         n  = $urandom_range(0, 60);
         m  = 32'd0;
         a0 = $urandom;
         a1 = $urandom;
`ifdef FIB_SEQ_MOD_EN
         m = $urandom;
         if ($urandom_range(0, 3) == 0) m = 32'd0;
         if (m != 32'd0 && $urandom_range(0, 4) != 0) begin
            a0 = a0 % m;
            a1 = a1 % m;
         end
`endif
         exp_q.push_back(ref_fib(n, 64'(a0), 64'(a1), 64'(m), 32));
         drive_start(1'b0, n, a0, a1, m);
         wait_done(1'b0, lat, res, ovf);
         exp = exp_q.pop_front();
         n_checks++;
         if (res !== exp[31:0] || ovf !== exp[32] || lat !== ((n < 1) ? 1 : n) + 1)
            $display("FAIL random[%0d] n=%0d: got ret=%0d ovf=%b edge=%0d expected ret=%0d ovf=%b edge=%0d",
                     i, n, res, ovf, lat, exp[31:0], exp[32], ((n < 1) ? 1 : n) + 1);
         else n_pass++;
      end
   endtask

`ifdef FIB_SEQ_MOD_EN
   task automatic test_mod8();
      int          ta0  [3] = '{0, 0, 9};
      int          tm   [3] = '{7, 0, 7};
      int          texp [3] = '{6, 55, 4};
      logic        tovf [3] = '{1'b0, 1'b0, 1'b1};
      int          lat;
      logic [31:0] res;
      logic        ovf;
      for (int i = 0; i < 3; i++) begin
         drive_start(1'b1, 10, 32'(ta0[i]), 32'd1, 32'(tm[i]));
         wait_done(1'b1, lat, res, ovf);
         n_checks++;
         if (res !== 32'(texp[i])) $display("FAIL mod8_return[%0d]: got %0d expected %0d", i, res, texp[i]);
         else n_pass++;
         n_checks++;
         if (ovf !== tovf[i]) $display("FAIL mod8_overflow[%0d]: got %b expected %b", i, ovf, tovf[i]);
         else n_pass++;
         n_checks++;
         if (lat !== 11) $display("FAIL mod8_latency[%0d]: got %0d expected 11", i, lat);
         else n_pass++;
      end
   endtask
`else
   task automatic test_wrap8();
      int          tn   [2] = '{14, 5};
      int          texp [2] = '{121, 5};
      logic        tovf [2] = '{1'b1, 1'b0};
      int          lat;
      logic [31:0] res;
      logic        ovf;
      for (int i = 0; i < 2; i++) begin
         drive_start(1'b1, tn[i], 32'd0, 32'd1, 32'd0);
         wait_done(1'b1, lat, res, ovf);
         n_checks++;
         if (res !== 32'(texp[i])) $display("FAIL wrap8_return[%0d]: got %0d expected %0d", i, res, texp[i]);
         else n_pass++;
         n_checks++;
         if (ovf !== tovf[i]) $display("FAIL wrap8_overflow[%0d]: got %b expected %b", i, ovf, tovf[i]);
         else n_pass++;
         n_checks++;
         if (lat !== tn[i] + 1) $display("FAIL wrap8_latency[%0d]: got %0d expected %0d", i, lat, tn[i] + 1);
         else n_pass++;
      end
   endtask
`endif

   task automatic test_ignore_start();
      int lat;
      int rises;
      logic prev_done;
      drive_start(1'b0, 10, 32'd0, 32'd1, 32'd0);
      lat       = -1;
      rises     = 0;
      prev_done = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge ap_clk);
         @(negedge ap_clk);
         if32.ap_start = (k >= 2 && k <= 4);
         if32.ap_n     = 32'd3;
         if (if32.ap_done === 1'b1 && prev_done === 1'b0) rises++;
         if (if32.ap_done === 1'b1 && lat < 0) lat = k;
         prev_done = if32.ap_done;
      end
      n_checks++;
      if (lat !== 11) $display("FAIL ignore_latency: got %0d expected 11", lat);
      else n_pass++;
      n_checks++;
      if (if32.ap_return !== 32'd55) $display("FAIL ignore_return: got %0d expected 55", if32.ap_return);
      else n_pass++;
      n_checks++;
      if (rises !== 1 || if32.ap_idle !== 1'b1)
         $display("FAIL ignore_single_run: got %0d done pulses idle=%b expected 1 pulse idle=1", rises, if32.ap_idle);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int          first;
      int          second;
      logic [31:0] r1;
      logic [31:0] r2;
      logic        idle1;
      logic        done_after;
      first      = -1;
      second     = -1;
      r1         = '0;
      r2         = '0;
      idle1      = 1'b0;
      done_after = 1'b1;
      @(negedge ap_clk);
      if32.ap_n     = 32'd3;
      if32.ap_a0    = 32'd0;
      if32.ap_a1    = 32'd1;
      if32.ap_start = 1'b1;
      for (int k = 0; k <= 30; k++) begin
         @(posedge ap_clk);
         @(negedge ap_clk);
         if (if32.ap_done === 1'b1 && first < 0) begin
            first      = k;
            r1         = if32.ap_return;
            idle1      = if32.ap_idle;
            if32.ap_n  = 32'd6;
            if32.ap_a0 = 32'd2;
            if32.ap_a1 = 32'd1;
         end else if (first >= 0 && k == first + 1) begin
            done_after    = if32.ap_done;
            if32.ap_start = 1'b0;
         end else if (first >= 0 && if32.ap_done === 1'b1 && second < 0) begin
            second = k;
            r2     = if32.ap_return;
         end
      end
      if32.ap_start = 1'b0;
      n_checks++;
      if (first !== 4 || r1 !== 32'd2 || idle1 !== 1'b1)
         $display("FAIL b2b_first: got edge=%0d ret=%0d idle=%b expected edge=4 ret=2 idle=1", first, r1, idle1);
      else n_pass++;
      n_checks++;
      if (done_after !== 1'b0) $display("FAIL b2b_done_clear: got %b expected 0", done_after);
      else n_pass++;
      n_checks++;
      if (second !== 12 || r2 !== 32'd18)
         $display("FAIL b2b_second: got edge=%0d ret=%0d expected edge=12 ret=18", second, r2);
      else n_pass++;
   endtask

   task automatic test_reset_abort();
      int          lat;
      logic [31:0] res;
      logic        ovf;
      int          spurious;
      drive_start(1'b0, 20, 32'hF000_0000, 32'hF000_0000, 32'd0);
      for (int k = 1; k <= 4; k++) begin
         @(posedge ap_clk);
         @(negedge ap_clk);
      end
      ap_rst = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
      n_checks++;
      if (if32.ap_idle !== 1'b1 || if32.ap_ready !== 1'b1 || if32.ap_done !== 1'b0 ||
          if32.ap_return !== 32'd0 || if32.ap_overflow !== 1'b0 || dbg32 !== IDLE)
         $display("FAIL abort_outputs: got idle=%b ready=%b done=%b ret=%0d ovf=%b expected 1 1 0 0 0",
                  if32.ap_idle, if32.ap_ready, if32.ap_done, if32.ap_return, if32.ap_overflow);
      else n_pass++;
      ap_rst   = 1'b0;
      spurious = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge ap_clk);
         @(negedge ap_clk);
         if (if32.ap_done !== 1'b0) spurious++;
      end
      n_checks++;
      if (spurious !== 0) $display("FAIL abort_no_done: got %0d done cycles expected 0", spurious);
      else n_pass++;
      drive_start(1'b0, 3, 32'd0, 32'd1, 32'd0);
      wait_done(1'b0, lat, res, ovf);
      n_checks++;
      if (res !== 32'd2 || lat !== 4 || ovf !== 1'b0)
         $display("FAIL abort_rerun: got ret=%0d edge=%0d ovf=%b expected ret=2 edge=4 ovf=0", res, lat, ovf);
      else n_pass++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      ap_rst        = 1'b1;
      if32.ap_start = 1'b0;
      if32.ap_n     = '0;
      if32.ap_a0    = '0;
      if32.ap_a1    = '0;
      if8.ap_start  = 1'b0;
      if8.ap_n      = '0;
      if8.ap_a0     = '0;
      if8.ap_a1     = '0;
`ifdef FIB_SEQ_MOD_EN
      if32.ap_m     = '0;
      if8.ap_m      = '0;
`endif
      apply_reset(3);
      @(negedge ap_clk);
      test_reset();
      test_basic();
      test_random();
`ifdef FIB_SEQ_MOD_EN
      test_mod8();
`else
      test_wrap8();
`endif
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
